systolic_array_wrapper: RTL and testbench

SYSTOLIC_ARRAY_WRAPPER -- requirements
Module: systolic_array_wrapper

---
 rtl/systolic_array_wrapper.sv | 152 +++++++++++++++
 tb/tb_systolic_array_wrapper.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/systolic_array_wrapper.sv
// systolic_array_wrapper: serially loaded 4x4 output-stationary systolic matrix multiplier.
// The controller sequences IDLE -> LOAD -> COMPUTE -> OUTPUT -> DONE; the top holds buffers, PEs and the result shifter.
module sa_ctrl (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    output logic [2:0] state_overall,
    output logic [1:0] state_load_id,
    output logic [1:0] state_load_row,
    output logic [3:0] state_compute_pump,
    output logic       state_compute_out,
    output logic [3:0] state_compute_out_counter
);
    localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_COMPUTE = 3'd2, S_OUTPUT = 3'd3, S_DONE = 3'd4;
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_overall             <= S_IDLE;
            state_load_id             <= 2'd0;
            state_load_row            <= 2'd0;
            state_compute_pump        <= 4'd0;
            state_compute_out         <= 1'b0;
            state_compute_out_counter <= 4'd0;
        end else begin
            case (state_overall)
                S_IDLE: if (en) state_overall <= S_LOAD;
                S_LOAD: begin
                    {state_load_row, state_load_id} <= {state_load_row, state_load_id} + 4'd1;
                    if ({state_load_row, state_load_id} == 4'd15) state_overall <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    state_compute_pump <= (state_compute_pump == 4'd9) ? 4'd0 : state_compute_pump + 4'd1;
                    if (state_compute_pump == 4'd9) begin
                        state_overall     <= S_OUTPUT;
                        state_compute_out <= 1'b1;
                    end
                end
                S_OUTPUT: begin
                    state_compute_out_counter <= state_compute_out_counter + 4'd1;
                    if (state_compute_out_counter == 4'd15) begin
                        state_overall     <= S_DONE;
                        state_compute_out <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

module systolic_array_wrapper (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic [7:0] shift_in_A,
    input  logic [7:0] shift_in_B,
    output logic [7:0] shift_out
);
    localparam logic [2:0] S_LOAD = 3'd1, S_COMPUTE = 3'd2;
    logic [2:0]  w_state;
    logic [1:0]  w_load_id, w_load_row;
    logic [3:0]  w_pump, w_out_cnt, w_oidx;
    logic        w_out_act, w_compute;
    logic [7:0]  r_a [4][4];
    logic [7:0]  r_b [4][4];
    logic [7:0]  w_fa [4];
    logic [7:0]  w_fb [4];
    logic [7:0]  w_pa [4][4];
    logic [7:0]  w_pb [4][4];
    logic [15:0] w_acc [4][4];

    sa_ctrl ctrl (
        .clk                       (clk),
        .rstn                      (rstn),
        .en                        (en),
        .state_overall             (w_state),
        .state_load_id             (w_load_id),
        .state_load_row            (w_load_row),
        .state_compute_pump        (w_pump),
        .state_compute_out         (w_out_act),
        .state_compute_out_counter (w_out_cnt)
    );

    assign w_compute = w_state == S_COMPUTE;
    assign w_oidx    = w_out_cnt + 4'd1;

    // Rows and columns arrive last-element-first, so the column/row index is reversed on capture.
    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    r_a[r][c] <= 8'd0;
                    r_b[r][c] <= 8'd0;
                end
        end else if (w_state == S_LOAD) begin
            r_a[w_load_row][2'd3 - w_load_id] <= shift_in_A;
            r_b[2'd3 - w_load_id][w_load_row] <= shift_in_B;
        end
    end

    // Edge feed: lane i carries element k = pump - i, zero outside the 0..3 window (the skew).
    for (genvar i = 0; i < 4; i++) begin : g_feed
        logic [3:0] w_k;
        logic       w_valid;
        assign w_k     = w_pump - 4'(i);
        assign w_valid = (w_pump >= 4'(i)) && (w_k < 4'd4);
        assign w_fa[i] = w_valid ? r_a[i][w_k[1:0]] : 8'd0;
        assign w_fb[i] = w_valid ? r_b[w_k[1:0]][i] : 8'd0;
    end

    for (genvar i = 0; i < 4; i++) begin : g_row
        for (genvar j = 0; j < 4; j++) begin : g_col
            logic [7:0]  w_ain, w_bin, r_pa, r_pb;
            logic [15:0] r_acc;
            if (j == 0) begin : g_al
                assign w_ain = w_fa[i];
            end else begin : g_ai
                assign w_ain = w_pa[i][j-1];
            end
            if (i == 0) begin : g_bt
                assign w_bin = w_fb[j];
            end else begin : g_bi
                assign w_bin = w_pb[i-1][j];
            end
            always_ff @(posedge clk) begin
                if (rstn) begin
                    r_pa  <= 8'd0;
                    r_pb  <= 8'd0;
                    r_acc <= 16'd0;
                end else if (w_compute) begin
                    r_pa  <= w_ain;
                    r_pb  <= w_bin;
                    r_acc <= r_acc + 16'(w_ain) * 16'(w_bin);
                end
            end
            assign w_pa[i][j]  = r_pa;
            assign w_pb[i][j]  = r_pb;
            assign w_acc[i][j] = r_acc;
        end
    end

    // C[0][0] is final well before the last pump, so it can be registered on the COMPUTE exit edge.
    always_ff @(posedge clk) begin
        if (rstn)
            shift_out <= 8'd0;
        else if (w_compute && w_pump == 4'd9)
            shift_out <= w_acc[0][0][7:0];
        else if (w_out_act && w_out_cnt != 4'd15)
            shift_out <= w_acc[w_oidx[3:2]][w_oidx[1:0]][7:0];
        else
            shift_out <= 8'd0;
    end
endmodule

// File: tb/tb_systolic_array_wrapper.sv
// tb_systolic_array_wrapper: directed checks of load/compute/output sequencing, results, wrap, gating and abort.
module tb_systolic_array_wrapper;
    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       en = 1'b0;
    logic [7:0] shift_in_A = 8'd0;
    logic [7:0] shift_in_B = 8'd0;
    logic [7:0] shift_out;
    int         n_cmp = 0;
    int         n_err = 0;
    int         ma [4][4];
    int         mb [4][4];
    int         exp_w [16];

    systolic_array_wrapper dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .shift_in_A (shift_in_A),
        .shift_in_B (shift_in_B),
        .shift_out  (shift_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rstn = 1'b1;
        en = 1'b0;
        tick;
        tick;
        rstn = 1'b0;
    endtask

    task automatic load_word(input int n);
        shift_in_A = 8'(ma[n/4][3 - n%4]);
        shift_in_B = 8'(mb[3 - n%4][n/4]);
    endtask

    task automatic run_op(input string tag, input logic hold_en);
        en = 1'b1;
        tick;
        en = hold_en;
        chk({tag, "_enter_load"}, 32'(dut.ctrl.state_overall), 1);
        for (int n = 0; n < 16; n++) begin
            load_word(n);
            if (n == 6) begin
                chk({tag, "_load_row"}, 32'(dut.ctrl.state_load_row), 1);
                chk({tag, "_load_id"}, 32'(dut.ctrl.state_load_id), 2);
            end
            tick;
        end
        chk({tag, "_enter_compute"}, 32'(dut.ctrl.state_overall), 2);
        chk({tag, "_compute_out0"}, 32'(shift_out), 0);
        repeat (10) tick;
        chk({tag, "_enter_output"}, 32'(dut.ctrl.state_overall), 3);
        for (int m = 0; m < 16; m++) begin
            chk($sformatf("%s_word%0d", tag, m), 32'(shift_out), 32'(exp_w[m]));
            if (m == 15) chk({tag, "_out_counter"}, 32'(dut.ctrl.state_compute_out_counter), 15);
            tick;
        end
        chk({tag, "_done"}, 32'(dut.ctrl.state_overall), 4);
        chk({tag, "_done_out"}, 32'(shift_out), 0);
    endtask

    initial begin
        do_reset;
        chk("rst_state", 32'(dut.ctrl.state_overall), 0);
        chk("rst_out", 32'(shift_out), 0);
        chk("rst_pump", 32'(dut.ctrl.state_compute_pump), 0);
        chk("rst_cnt", 32'(dut.ctrl.state_compute_out_counter), 0);
        repeat (50) tick;
        chk("idle50_state", 32'(dut.ctrl.state_overall), 0);
        chk("idle50_out", 32'(shift_out), 0);

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = c + 1;
                mb[r][c] = r + 1;
            end
        for (int m = 0; m < 16; m++) exp_w[m] = 30;
        run_op("t022", 1'b0);
        en = 1'b1;
        repeat (5) tick;
        chk("done_ignores_en", 32'(dut.ctrl.state_overall), 4);
        chk("done_hold_out", 32'(shift_out), 0);
        do_reset;
        chk("rst_from_done", 32'(dut.ctrl.state_overall), 0);

        ma = '{'{1, 1, 1, 1}, '{1, 0, 0, 1}, '{1, 0, 0, 1}, '{1, 1, 1, 1}};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) mb[r][c] = 2 * (4 * r + c) + 12;
        exp_w = '{96, 104, 112, 120, 48, 52, 56, 60, 48, 52, 56, 60, 96, 104, 112, 120};
        run_op("t023", 1'b0);
        do_reset;

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) ma[r][c] = 3 * (4 * r + c);
        mb = '{'{2, 0, 0, 1}, '{0, 2, 1, 0}, '{0, 1, 2, 0}, '{1, 0, 0, 2}};
        exp_w = '{9, 12, 15, 18, 45, 48, 51, 54, 81, 84, 87, 90, 117, 120, 123, 126};
        run_op("t024", 1'b0);
        do_reset;

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = 10;
                mb[r][c] = 10;
            end
        for (int m = 0; m < 16; m++) exp_w[m] = 144;
        run_op("t025_hold_en", 1'b1);
        repeat (5) tick;
        chk("t026_no_retrigger", 32'(dut.ctrl.state_overall), 4);
        chk("t026_done_out", 32'(shift_out), 0);
        en = 1'b0;
        do_reset;

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = c + 1;
                mb[r][c] = r + 1;
            end
        en = 1'b1;
        tick;
        en = 1'b0;
        for (int n = 0; n < 7; n++) begin
            load_word(n);
            tick;
        end
        chk("abort_at_row", 32'(dut.ctrl.state_load_row), 1);
        chk("abort_at_id", 32'(dut.ctrl.state_load_id), 3);
        rstn = 1'b1;
        shift_in_A = 8'hff;
        shift_in_B = 8'hff;
        tick;
        rstn = 1'b0;
        chk("abort_state", 32'(dut.ctrl.state_overall), 0);
        chk("abort_row", 32'(dut.ctrl.state_load_row), 0);
        chk("abort_id", 32'(dut.ctrl.state_load_id), 0);
        chk("abort_buf_a", 32'(dut.r_a[0][0]), 0);
        chk("abort_buf_b", 32'(dut.r_b[0][0]), 0);
        chk("abort_out", 32'(shift_out), 0);
        for (int m = 0; m < 16; m++) exp_w[m] = 30;
        run_op("t027", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
